// File: rtl/sll_seq.sv
// Multi-cycle logical shift-left unit: out = a << b[SHAMT_W-1:0], one bit per clock.
// Operands and results move through valid/ready handshakes; no overlap between operations.
module sll_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]   acc_shl;
    logic [SHAMT_W-1:0] cnt_reg, cnt_next;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    // Single-position shift: zero enters at the LSB, the MSB falls off.
    assign acc_shl[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shl
            assign acc_shl[gi] = acc_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    acc_next   = a;
                    cnt_next   = shamt;
                    state_next = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_next = acc_shl;
                cnt_next = cnt_reg - 1'b1;
                // cnt==1 means this edge performs the final shift.
                if (cnt_reg == SHAMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out       = acc_reg;

endmodule

// File: tb/tb_sll_seq.sv
// Scoreboard bench for sll_seq: stimulus pushes model results at accept time,
// a negedge monitor compares data and latency whenever a result is presented.
module tb_sll_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;

    typedef struct {
        logic [31:0] data;
        int          sh;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   seen = 1'b0;
    bit   rdy_mode = 1'b0;
    bit   rdy_fixed = 1'b0;

    sll_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: multiply by 2**(b mod 32) and keep the low 32 bits.
    function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] p;
        p = {32'd0, av} * (64'd1 << (bv % 32));
        return p[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // out_ready changes just after the rising edge so it is stable at every negedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("ready_vs_busy", {63'd0, in_ready}, {63'd0, !busy});
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got out=%0h, required no result", out);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].sh + 1));
                    end
                    check("out", {32'd0, out}, {32'd0, sb[0].data});
                    check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Present operands until accepted; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv);
        bit done;
        exp_t e;
        done = 1'b0;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            if (in_ready) begin
                e.data = model(av, bv);
                e.sh = int'(bv % 32);
                e.acc_cyc = cyc;
                sb.push_back(e);
                $display("issue a=%08h b=%08h exp=%08h", av, bv, e.data);
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0, required 1");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic issue_count_busy(input logic [31:0] av, input logic [31:0] bv);
        int n;
        issue(av, bv);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(int'(bv % 32) + 1));
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic check_reset_state();
        check("rst_out", {32'd0, out}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state();
        mon_en = 1'b1;

        // Basic shift, zero shift, full shift, upper b bits ignored.
        rdy_fixed = 1'b1;
        repeat (2) @(negedge clk);
        issue_count_busy(32'h0000_0001, 32'd4);
        issue_count_busy(32'hDEAD_BEEF, 32'd0);
        issue(32'hFFFF_FFFF, 32'd31);
        drain();
        issue(32'h8000_0001, 32'hFFFF_FFE5);
        drain();

        // Backpressure: result held, new operands refused until handoff.
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        issue(32'h0000_00F0, 32'd8);
        for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
        a = 32'h0000_1234;
        b = 32'd3;
        in_valid = 1'b1;
        repeat (4) begin
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out", {32'd0, out}, 64'h0000_F000);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            @(negedge clk);
        end
        rdy_fixed = 1'b1;
        issue(32'h0000_1234, 32'd3);
        drain();

        // Reset during SHIFT discards the operation.
        issue(32'h0000_0001, 32'd20);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state();
        issue(32'h0000_0003, 32'd2);
        drain();

        // Random regression with random gaps and consumer stalls.
        rdy_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue($urandom, $urandom);
        end
        rdy_mode = 1'b0;
        rdy_fixed = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
